// File: rtl/serial_word_collector_if.sv
// Bus bundle for serial_word_collector: serial beat input, clear, and the
// word holding-register handshake. The collector uses the slave modport.
interface serial_word_collector_if #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int LANES        = 1
);
  logic [LANES-1:0]        serial_in;
  logic                    serial_valid;
  logic                    clear;
  logic [OUTPUT_WIDTH-1:0] data;
  logic                    data_valid;
  logic                    data_ack;
  logic                    overflow;
  logic                    parity_err;

  modport master (
    output serial_in, serial_valid, clear, data_ack,
    input  data, data_valid, overflow, parity_err
  );

  modport slave (
    input  serial_in, serial_valid, clear, data_ack,
    output data, data_valid, overflow, parity_err
  );
endinterface

// File: rtl/serial_word_collector.sv
// Deserialises LANES bits per beat into OUTPUT_WIDTH-bit words behind a valid/ack
// holding register. Define SERIAL_WORD_COLLECTOR_PARITY_EN for a trailing even-parity beat.
module serial_word_collector #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int LANES        = 1,
  parameter bit LSB_FIRST    = 1'b1
) (
  input logic               fast_clk,
  input logic               reset,
  serial_word_collector_if.slave bus
);

  localparam int N  = OUTPUT_WIDTH / LANES;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  localparam logic [CW-1:0] PAR_IDX_C = CW'(N);
`endif

  typedef enum logic [0:0] {
    S_SHIFT  = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [OUTPUT_WIDTH-1:0] sr_q, sr_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    perr_q, perr_d;

  logic [OUTPUT_WIDTH-1:0] shifted_s;
  logic [OUTPUT_WIDTH-1:0] word_s;
  logic                    complete_s;
  logic                    perr_s;

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_mismatch(input logic [OUTPUT_WIDTH-1:0] word,
                                           input logic                    pbit);
    return (^word) ^ pbit;
  endfunction
`endif

  // After N shifts the register holds the whole word in its final placement.
  generate
    if (LANES == OUTPUT_WIDTH) begin : g_full
      assign shifted_s = bus.serial_in;
    end else if (LSB_FIRST) begin : g_lsb
      assign shifted_s = {bus.serial_in, sr_q[OUTPUT_WIDTH-1:LANES]};
    end else begin : g_msb
      assign shifted_s = {sr_q[OUTPUT_WIDTH-LANES-1:0], bus.serial_in};
    end
  endgenerate

  // Next-state: beat acceptance, word completion and holding-register handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    perr_d     = perr_q;
    word_s     = shifted_s;
    complete_s = 1'b0;
    perr_s     = 1'b0;

    if (bus.clear) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      sr_d    = '0;
      ovf_d   = 1'b0;
    end else if (bus.serial_valid) begin
      case (state_q)
        S_SHIFT: begin
          sr_d = shifted_s;
          if (cnt_q == LAST_C) begin
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
            cnt_d   = PAR_IDX_C;
            state_d = S_PARITY;
`else
            cnt_d      = '0;
            complete_s = 1'b1;
            word_s     = shifted_s;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
        S_PARITY: begin
          complete_s = 1'b1;
          word_s     = sr_q;
          perr_s     = parity_mismatch(sr_q, bus.serial_in[0]);
          cnt_d      = '0;
          state_d    = S_SHIFT;
        end
`endif
        default: begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // An ack in the completion cycle frees the slot for the new word.
    if (complete_s) begin
      if (!valid_q || bus.data_ack) begin
        data_d  = word_s;
        valid_d = 1'b1;
        perr_d  = perr_s;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.data_ack && valid_q) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_SHIFT;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overflow   = ovf_q;
  assign bus.parity_err = perr_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector: two instances (1-lane LSB-first,
// 4-lane MSB-first) checked every cycle against a word-level model.
module tb_serial_word_collector;

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic fast_clk;
  logic rst_n;
  logic [3:0] sin [2];
  logic       sv  [2];
  logic       clr [2];
  logic       ack [2];
  int total;
  int bad;

  serial_word_collector_if #(.OUTPUT_WIDTH(16), .LANES(1)) ifa ();
  serial_word_collector_if #(.OUTPUT_WIDTH(16), .LANES(4)) ifb ();

  assign ifa.serial_in    = sin[0][0:0];
  assign ifa.serial_valid = sv[0];
  assign ifa.clear        = clr[0];
  assign ifa.data_ack     = ack[0];
  assign ifb.serial_in    = sin[1];
  assign ifb.serial_valid = sv[1];
  assign ifb.clear        = clr[1];
  assign ifb.data_ack     = ack[1];

  serial_word_collector #(.OUTPUT_WIDTH(16), .LANES(1), .LSB_FIRST(1'b1)) dut_a (
    .fast_clk(fast_clk), .reset(rst_n), .bus(ifa.slave));
  serial_word_collector #(.OUTPUT_WIDTH(16), .LANES(4), .LSB_FIRST(1'b0)) dut_b (
    .fast_clk(fast_clk), .reset(rst_n), .bus(ifb.slave));

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  typedef struct packed {
    logic [7:0]  cnt;
    logic [15:0] acc;
    logic [15:0] data;
    logic        valid;
    logic        ovf;
    logic        perr;
  } mst_t;

  mst_t m [2];

  // Word-level model: beats are OR-ed into their spec position; completion
  // is the N-th data beat (or the parity beat after it).
  function automatic mst_t step(mst_t c, logic [3:0] beat, logic v, logic cl,
                                logic a, int lanes, bit lsb);
    mst_t x = c;
    int n = 16 / lanes;
    int pos;
    logic done = 1'b0;
    logic pe = 1'b0;
    logic [15:0] w = c.acc;
    logic [15:0] mask = 16'((1 << lanes) - 1);
    if (cl) begin
      x.cnt = 8'd0; x.acc = 16'd0; x.ovf = 1'b0;
    end else if (v) begin
      if (int'(c.cnt) < n) begin
        pos = lsb ? int'(c.cnt) * lanes : 16 - (int'(c.cnt) + 1) * lanes;
        w = c.acc | ((16'(beat) & mask) << pos);
        x.acc = w;
        x.cnt = c.cnt + 8'd1;
      end
      if (int'(c.cnt) == n - 1 + PAR) begin
        done = 1'b1;
        pe = (PAR != 0) ? ((^c.acc) ^ beat[0]) : 1'b0;
        x.cnt = 8'd0;
        x.acc = 16'd0;
      end
    end
    if (done) begin
      if (!c.valid || a) begin
        x.data = w; x.valid = 1'b1; x.perr = pe;
      end else begin
        x.ovf = 1'b1;
      end
    end else if (a && c.valid) begin
      x.valid = 1'b0;
    end
    return x;
  endfunction

  always @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= step(m[0], sin[0], sv[0], clr[0], ack[0], 1, 1'b1);
      m[1] <= step(m[1], sin[1], sv[1], clr[1], ack[1], 4, 1'b0);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge fast_clk) begin
    if (rst_n) begin
      chk("a_data",  ifa.data,               m[0].data);
      chk("a_valid", 16'(ifa.data_valid),    16'(m[0].valid));
      chk("a_ovf",   16'(ifa.overflow),      16'(m[0].ovf));
      chk("a_perr",  16'(ifa.parity_err),    16'(m[0].perr));
      chk("b_data",  ifb.data,               m[1].data);
      chk("b_valid", 16'(ifb.data_valid),    16'(m[1].valid));
      chk("b_ovf",   16'(ifb.overflow),      16'(m[1].ovf));
      chk("b_perr",  16'(ifb.parity_err),    16'(m[1].perr));
    end
  end

  function automatic logic [3:0] beat_of(int d, logic [15:0] w, int k);
    logic [15:0] s;
    if (d == 0) return {3'b000, w[k]};
    s = w >> (12 - 4 * k);
    return s[3:0];
  endfunction

  // ack_at: beat index carrying data_ack, -1 none, -2 the completing beat.
  task automatic send_word(input int d, input logic [15:0] w, input int ack_at, input bit flip);
    int n = (d == 0) ? 16 : 4;
    int nb = n + PAR;
    for (int k = 0; k < nb; k++) begin
      @(negedge fast_clk);
      sv[d]  = 1'b1;
      clr[d] = 1'b0;
      ack[d] = (k == ack_at) || (ack_at == -2 && k == nb - 1);
      if (k < n) sin[d] = beat_of(d, w, k);
      else       sin[d] = {3'b101, (^w) ^ flip};
    end
  endtask

  task automatic idle();
    @(negedge fast_clk);
    for (int d = 0; d < 2; d++) begin
      sv[d] = 1'b0; clr[d] = 1'b0; ack[d] = 1'b0; sin[d] = 4'h0;
    end
  endtask

  task automatic ack_cycle(input int d);
    @(negedge fast_clk);
    sv[d] = 1'b0; ack[d] = 1'b1;
    idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_data"},  ifa.data, 16'h0000);
    chk({tag, "_a_flags"}, 16'({ifa.data_valid, ifa.overflow, ifa.parity_err}), 16'h0000);
    chk({tag, "_b_data"},  ifb.data, 16'h0000);
    chk({tag, "_b_flags"}, 16'({ifb.data_valid, ifb.overflow, ifb.parity_err}), 16'h0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sv[d] = 1'b0; clr[d] = 1'b0; ack[d] = 1'b0; sin[d] = 4'h0;
    end
    repeat (2) @(negedge fast_clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle();
    chk_zero("post_reset");

    send_word(0, 16'hA5C3, -1, 1'b0);
    idle();
    chk("a5c3_data", ifa.data, 16'hA5C3);
    chk("a5c3_valid", 16'(ifa.data_valid), 16'h0001);
    chk("a5c3_ovf", 16'(ifa.overflow), 16'h0000);

    send_word(1, 16'h1234, -1, 1'b0);
    idle();
    chk("w1234_data", ifb.data, 16'h1234);
    send_word(1, 16'h5678, -1, 1'b0);
    send_word(1, 16'hBEEF, -2, 1'b0);
    idle();
    chk("beef_data", ifb.data, 16'hBEEF);
    chk("beef_ovf", 16'(ifb.overflow), 16'h0001);
    @(negedge fast_clk); clr[1] = 1'b1;
    idle();
    chk("b_clr_ovf", 16'(ifb.overflow), 16'h0000);
    ack_cycle(1);
    chk("b_ack_valid", 16'(ifb.data_valid), 16'h0000);
    send_word(1, 16'h1234, -1, 1'b0);
    send_word(1, 16'hBEEF, -2, 1'b0);
    idle();
    chk("b2b_beef_data", ifb.data, 16'hBEEF);
    chk("b2b_beef_ovf", 16'(ifb.overflow), 16'h0000);
    chk("b2b_beef_valid", 16'(ifb.data_valid), 16'h0001);

    ack_cycle(1);
    send_word(1, 16'hCAFE, -1, 1'b0);
    send_word(1, 16'h0F0F, 0, 1'b0);
    idle();
    chk("stall_data", ifb.data, 16'h0F0F);
    chk("stall_ovf", 16'(ifb.overflow), 16'h0000);

    ack_cycle(0);
    chk("a_ack_valid", 16'(ifa.data_valid), 16'h0000);
    send_word(0, 16'h1111, -1, 1'b0);
    send_word(0, 16'h2222, -1, 1'b0);
    idle();
    chk("ovf_data", ifa.data, 16'h1111);
    chk("ovf_flag", 16'(ifa.overflow), 16'h0001);
    @(negedge fast_clk); clr[0] = 1'b1;
    idle();
    chk("clr_ovf", 16'(ifa.overflow), 16'h0000);
    chk("clr_valid", 16'(ifa.data_valid), 16'h0001);
    chk("clr_data", ifa.data, 16'h1111);

    ack_cycle(0);
    for (int k = 0; k < 7; k++) begin
      @(negedge fast_clk); sv[0] = 1'b1; sin[0] = 4'h1;
    end
    @(negedge fast_clk); sv[0] = 1'b1; sin[0] = 4'h1; clr[0] = 1'b1;
    send_word(0, 16'h00FF, -2, 1'b0);
    idle();
    chk("midclr_data", ifa.data, 16'h00FF);

    for (int k = 0; k < 5; k++) begin
      @(negedge fast_clk); sv[0] = 1'b1; sin[0] = {3'b000, k[0]};
    end
    @(posedge fast_clk);
    #2;
    sv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    @(negedge fast_clk);
    rst_n = 1'b1;
    send_word(0, 16'h5A3C, -1, 1'b0);
    idle();
    chk("after_rst_data", ifa.data, 16'h5A3C);
    chk("after_rst_valid", 16'(ifa.data_valid), 16'h0001);

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
    ack_cycle(0);
    for (int k = 0; k < 16; k++) begin
      @(negedge fast_clk); sv[0] = 1'b1; sin[0] = (k == 0) ? 4'h1 : 4'h0;
    end
    @(negedge fast_clk);
    chk("par_wait_valid", 16'(ifa.data_valid), 16'h0000);
    sv[0] = 1'b1; sin[0] = 4'h1;
    idle();
    chk("par_ok_valid", 16'(ifa.data_valid), 16'h0001);
    chk("par_ok_err", 16'(ifa.parity_err), 16'h0000);
    ack_cycle(0);
    send_word(0, 16'h0001, -1, 1'b1);
    idle();
    chk("par_bad_err", 16'(ifa.parity_err), 16'h0001);
    chk("par_bad_data", ifa.data, 16'h0001);
`endif

    repeat (3) idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
